// File: rtl/lfsr_rr_scheduler_if.sv
// Bundle between the LFSR round-robin scheduler, its external LFSR and the consumers.
// master = scheduler side, slave = LFSR/consumer side.
interface lfsr_rr_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    lfsr_q;
  logic            lfsr_en;
  logic [NREQ-1:0] gnt;
  logic            rvalid;
  logic [W-1:0]    rdata;
  logic            busy;
  logic            lock_err;

  modport master (
    input  req, ack, lfsr_q,
    output lfsr_en, gnt, rvalid, rdata, busy, lock_err
  );

  modport slave (
    output req, ack, lfsr_q,
    input  lfsr_en, gnt, rvalid, rdata, busy, lock_err
  );
endinterface

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin arbiter sharing one external LFSR: STEPS shifts per grant, then valid/ack handoff.
// Optional macro LFSR_SCHED_FREERUN_EN: LFSR free-runs while idle with no request.
module lfsr_rr_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned STEPS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  lfsr_rr_scheduler_if.master bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, STEP, GRANT} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   last, last_d;
  logic [IW-1:0]   win, win_d;
  logic [IW-1:0]   pick;
  logic            found;
  logic            lock_err, lock_set;
  logic            en_q, en_d;
  logic            rvalid_q, rvalid_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  // Zero state is caught in the same cycle so a locked LFSR never reaches GRANT.
  assign lock_set = lock_err | (bus.lfsr_q == '0);

  // Rotating-priority search starting just above the last winner.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last) + i) % NREQ;
      if (!found && bus.req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    win_d   = win;
    case (state)
      IDLE: begin
        if (!lock_set && found) begin
          win_d   = pick;
          cnt_d   = CW'(STEPS);
          state_d = STEP;
        end
      end
      STEP: begin
        cnt_d = cnt - CW'(1);
        if (lock_set)             state_d = IDLE;
        else if (cnt == CW'(1))   state_d = GRANT;
      end
      GRANT: begin
        if (lock_set) begin
          state_d = IDLE;
        end else if (bus.ack[win] || !bus.req[win]) begin
          last_d  = win;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    en_d = (state_d == STEP);
`ifdef LFSR_SCHED_FREERUN_EN
    if (state_d == IDLE && !lock_set && !found) en_d = 1'b1;
`endif
    rvalid_d = (state_d == GRANT);
    gnt_d    = (state_d == GRANT) ? (NREQ'(1) << win_d) : '0;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= IW'(NREQ - 1);
      win      <= '0;
      lock_err <= 1'b0;
      en_q     <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      last     <= last_d;
      win      <= win_d;
      lock_err <= lock_set;
      en_q     <= en_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
    end
  end

  assign bus.lfsr_en  = en_q;
  assign bus.gnt      = gnt_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.busy     = busy_q;
  assign bus.lock_err = lock_err;
  // LFSR is frozen during GRANT, so passing lfsr_q straight through is stable.
  assign bus.rdata    = rvalid_q ? bus.lfsr_q : '0;
endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed bench for lfsr_rr_scheduler with a behavioural 16-bit right-shift LFSR.
module tb_lfsr_rr_scheduler;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;
  logic force_zero;
  logic [15:0] lq;
  int errors = 0;
  int checks = 0;

  lfsr_rr_scheduler_if #(.NREQ(4), .W(16)) sif ();

  lfsr_rr_scheduler #(.NREQ(4), .W(16), .STEPS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] adv(input int n);
    logic [15:0] s;
    s = SEED;
    for (int k = 0; k < n; k++) s = lstep(s);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lq <= SEED;
    else if (sif.lfsr_en) lq <= lstep(lq);
  end
  assign sif.lfsr_q = force_zero ? 16'h0000 : lq;

  typedef struct {
    logic        do_rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        en;
    logic [3:0]  gnt;
    logic        rvalid;
    logic        busy;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [3:0] gnt,
                         input logic rvalid, input logic busy, input logic [15:0] rdata);
    chk({tag, ".en"},     32'(sif.lfsr_en), 32'(en));
    chk({tag, ".gnt"},    32'(sif.gnt),     32'(gnt));
    chk({tag, ".rvalid"}, 32'(sif.rvalid),  32'(rvalid));
    chk({tag, ".busy"},   32'(sif.busy),    32'(busy));
    chk({tag, ".rdata"},  32'(sif.rdata),   32'(rdata));
  endtask

  task automatic do_reset(input string tag);
    sif.req = '0;
    sif.ack = '0;
    force_zero = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out({tag, ".rst"}, 1'b0, 4'b0, 1'b0, 1'b0, 16'h0);
    chk({tag, ".rst.lock"}, 32'(sif.lock_err), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic v(input logic r, input logic [3:0] rq, input logic [3:0] ak, input logic en,
                   input logic [3:0] g, input logic rv, input logic b, input logic [15:0] d);
    vec_t x;
    x.do_rst = r; x.req = rq; x.ack = ak; x.en = en;
    x.gnt = g; x.rvalid = rv; x.busy = b; x.rdata = d;
    vecs.push_back(x);
  endtask

  // Four enable rows then the grant row, expecting the LFSR advanced by 'shifts'.
  task automatic run_grant(input string tag, input logic [3:0] rq, input logic [3:0] g, input int shifts);
    sif.req = rq;
    sif.ack = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("%s.step%0d", tag, k), 1'b1, 4'b0, 1'b0, 1'b1, 16'h0);
    end
    tick();
    chk_out({tag, ".grant"}, 1'b0, g, 1'b1, 1'b1, adv(shifts));
  endtask

  initial begin
    rst_n = 1'b0;
    force_zero = 1'b0;
    sif.req = '0;
    sif.ack = '0;

    // Single request, then ack.
    v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) v(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 1, 16'h0);
    v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, adv(4));
    v(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 16'h0);
    v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'h0);
    // Wrong ack is ignored; grant held until ack[0].
    v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) v(0, 4'b0011, 4'b0000, 1, 4'b0000, 0, 1, 16'h0);
    v(0, 4'b0011, 4'b0000, 0, 4'b0001, 1, 1, adv(4));
    v(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 1, adv(4));
    v(0, 4'b0011, 4'b0010, 0, 4'b0001, 1, 1, adv(4));
    v(0, 4'b0011, 4'b0001, 0, 4'b0000, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) v(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 1, 16'h0);
    v(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, adv(8));
    v(0, 4'b0010, 4'b0010, 0, 4'b0000, 0, 0, 16'h0);
    // Abandon requester 2, then 0 wins over 2.
    v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) v(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 1, 16'h0);
    v(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, adv(4));
    v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) v(0, 4'b0101, 4'b0000, 1, 4'b0000, 0, 1, 16'h0);
    v(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 1, adv(8));
    v(0, 4'b0101, 4'b0001, 0, 4'b0000, 0, 0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) begin
        do_reset($sformatf("v%0d", i));
      end else begin
        sif.req = vecs[i].req;
        sif.ack = vecs[i].ack;
        tick();
        chk_out($sformatf("v%0d", i), vecs[i].en, vecs[i].gnt, vecs[i].rvalid,
                vecs[i].busy, vecs[i].rdata);
      end
    end

    // All requesting: rotation 0,1,2,3,0 with an IDLE cycle after each ack.
    do_reset("all");
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int j = 0; j < 5; j++) begin
        run_grant($sformatf("all%0d", j), 4'b1111, 4'(1 << order[j]), 4 * (j + 1));
        sif.ack = 4'(1 << order[j]);
        tick();
        chk_out($sformatf("all%0d.idle", j), 1'b0, 4'b0, 1'b0, 1'b0, 16'h0);
        sif.ack = '0;
      end
    end

    // Lockup during STEP: sticky error, no further grants, cleared only by reset.
    do_reset("lock");
    sif.req = 4'b0001;
    tick();
    chk("lock.en1", 32'(sif.lfsr_en), 32'd1);
    tick();
    force_zero = 1'b1;
    tick();
    chk("lock.set", 32'(sif.lock_err), 32'd1);
    force_zero = 1'b0;
    sif.req = 4'b1111;
    tick();
    tick();
    tick();
    chk("lock.busy", 32'(sif.busy), 32'd0);
    chk("lock.en", 32'(sif.lfsr_en), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("lock.gnt%0d", k), 32'(sif.gnt), 32'd0);
      chk($sformatf("lock.rv%0d", k), 32'(sif.rvalid), 32'd0);
      chk($sformatf("lock.sticky%0d", k), 32'(sif.lock_err), 32'd1);
    end

    // Reset on the 2nd enable cycle drops outputs asynchronously.
    do_reset("mid");
    sif.req = 4'b0001;
    tick();
    chk("mid.en1", 32'(sif.lfsr_en), 32'd1);
    tick();
    chk("mid.en2", 32'(sif.lfsr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.en_drop", 32'(sif.lfsr_en), 32'd0);
    chk("mid.gnt_drop", 32'(sif.gnt), 32'd0);
    chk("mid.busy_drop", 32'(sif.busy), 32'd0);
    sif.req = '0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_grant("mid.again", 4'b0001, 4'b0001, 4);
    sif.ack = 4'b0001;
    tick();
    chk_out("mid.idle", 1'b0, 4'b0, 1'b0, 1'b0, 16'h0);
    sif.ack = '0;
    sif.req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
